// File: rtl/tx_serializer_if.sv
// Parallel word handshake between a word source and tx_serializer.
interface tx_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/tx_serializer.sv
// Parallel-to-serial transmitter for a 1-bit DAC: one-word hold buffer,
// gapless back-to-back words, sticky underflow flag and a PRBS7 test source.
module tx_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_VAL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            prbs_en,
    input  logic            clr_err,
    tx_serializer_if.slave  bus,
    output logic            dout,
    output logic            word_start,
    output logic            underflow
);
    localparam int unsigned      CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [6:0]       lfsr_q, lfsr_d;
    logic             dout_q, dout_d;
    logic             ws_q, ws_d;
    logic             uf_q, uf_d;
    logic             ready;
    logic             accept;
    logic             transfer;
    logic             set_uf;

    // Bit of a word sent at position idx in transmission order.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
        logic [CW-1:0] pos;
        pos = MSB_FIRST ? (LAST - idx) : idx;
        return w[pos];
    endfunction

    assign ready         = en & ~prbs_en & ~hold_full_q & ~rst;
    assign bus.din_ready = ready;
    assign dout          = dout_q;
    assign word_start    = ws_q;
    assign underflow     = uf_q;

    // Next-state logic: handshake, word transfer, bit shifting, PRBS and underflow.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        dout_d      = dout_q;
        ws_d        = 1'b0;
        uf_d        = uf_q;
        set_uf      = 1'b0;
        accept      = bus.din_valid & ready;
        transfer    = en & ~prbs_en & hold_full_q &
                      ((state_q == IDLE) || (cnt_q == LAST));

        if (en) begin
            if (prbs_en) begin
                lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                dout_d  = lfsr_q[6];
                state_d = IDLE;
                uf_d    = 1'b0;
            end else begin
                if (transfer) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                    dout_d      = pick(hold_q, '0);
                    ws_d        = 1'b1;
                end else if (state_q == SHIFT) begin
                    if (cnt_q != LAST) begin
                        cnt_d  = cnt_q + CW'(1);
                        dout_d = pick(shreg_q, cnt_q + CW'(1));
                    end else begin
                        state_d = IDLE;
                        dout_d  = IDLE_VAL;
                        set_uf  = 1'b1;
                    end
                end else begin
                    dout_d = IDLE_VAL;
                end

                // A fresh underflow wins over a simultaneous clear.
                if (set_uf) begin
                    uf_d = 1'b1;
                end else if (clr_err) begin
                    uf_d = 1'b0;
                end

                // Acceptance never coincides with a transfer: ready needs an empty hold.
                if (accept) begin
                    hold_d      = bus.din;
                    hold_full_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset; en=0 is handled by the hold defaults above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            lfsr_q      <= 7'h7F;
            dout_q      <= IDLE_VAL;
            ws_q        <= 1'b0;
            uf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            dout_q      <= dout_d;
            ws_q        <= ws_d;
            uf_q        <= uf_d;
        end
    end
endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_tx_serializer;
    localparam int unsigned W    = 8;
    localparam logic        IDLE = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic prbs_en = 1'b0;
    logic clr_err = 1'b0;
    logic dout0, ws0, uf0;
    logic dout1, ws1, uf1;

    tx_serializer_if #(.WIDTH(W)) bus0 ();
    tx_serializer_if #(.WIDTH(W)) bus1 ();

    tx_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_VAL(IDLE)) u0 (
        .clk(clk), .rst(rst), .en(en), .prbs_en(prbs_en), .clr_err(clr_err),
        .bus(bus0.slave), .dout(dout0), .word_start(ws0), .underflow(uf0)
    );

    tx_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_VAL(IDLE)) u1 (
        .clk(clk), .rst(rst), .en(en), .prbs_en(prbs_en), .clr_err(clr_err),
        .bus(bus1.slave), .dout(dout1), .word_start(ws1), .underflow(uf1)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes a queue of bits in send order.
    logic           bitq[$];
    logic           held_v = 1'b0;
    logic [W-1:0]   held_w = '0;
    logic           active = 1'b0;
    logic           m_dout = IDLE;
    logic           m_ws = 1'b0;
    logic           m_uf = 1'b0;
    logic [6:0]     m_lfsr = 7'h7F;

    task automatic model_edge(input logic r, input logic e, input logic p, input logic c,
                              input logic v, input logic [W-1:0] d);
        logic acc;
        logic new_uf;
        if (r) begin
            bitq.delete();
            held_v = 1'b0;
            active = 1'b0;
            m_dout = IDLE;
            m_ws   = 1'b0;
            m_uf   = 1'b0;
            m_lfsr = 7'h7F;
        end else if (!e) begin
            m_ws = 1'b0;
        end else if (p) begin
            m_dout = m_lfsr[6];
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            bitq.delete();
            active = 1'b0;
            m_ws   = 1'b0;
            m_uf   = 1'b0;
        end else begin
            acc    = v && !held_v;
            new_uf = 1'b0;
            m_ws   = 1'b0;
            if (held_v && bitq.size() == 0) begin
                for (int i = W - 1; i >= 0; i--) bitq.push_back(held_w[i]);
                m_dout = bitq.pop_front();
                m_ws   = 1'b1;
                held_v = 1'b0;
                active = 1'b1;
            end else if (bitq.size() > 0) begin
                m_dout = bitq.pop_front();
            end else if (active) begin
                m_dout = IDLE;
                active = 1'b0;
                new_uf = 1'b1;
            end else begin
                m_dout = IDLE;
            end
            if (new_uf) m_uf = 1'b1;
            else if (c) m_uf = 1'b0;
            if (acc) begin
                held_v = 1'b1;
                held_w = d;
            end
        end
    endtask

    // Per-cycle comparison of u0 against the model, 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            model_edge(rst, en, prbs_en, clr_err, bus0.din_valid, bus0.din);
            #1;
            check("dout", dout0, m_dout);
            check("word_start", ws0, m_ws);
            check("underflow", uf0, m_uf);
            check("din_ready", bus0.din_ready, en & ~prbs_en & ~held_v & ~rst);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [7:0]  pat;
    logic [15:0] exp16;
    logic [7:0]  words[2];
    logic        prbs_bits[254];

    initial begin
        bus0.din = '0; bus0.din_valid = 1'b0;
        bus1.din = '0; bus1.din_valid = 1'b0;

        // Reset state
        rst = 1'b1;
        step(); step();
        check("rst_dout", dout0, IDLE);
        check("rst_ws", ws0, 1'b0);
        check("rst_uf", uf0, 1'b0);
        check("rst_ready", bus0.din_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus0.din_ready, 1'b1);

        // Single word A5, MSB first, then underflow
        bus0.din = 8'hA5; bus0.din_valid = 1'b1;
        step();
        check("t1_ready_held", bus0.din_ready, 1'b0);
        bus0.din_valid = 1'b0;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_bit", dout0, pat[7 - i]);
            check("t1_ws", ws0, (i == 0));
        end
        step();
        check("t1_idle", dout0, IDLE);
        check("t1_uf", uf0, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t1_clr", uf0, 1'b0);

        // Continuous stream F0, 0F
        words[0] = 8'hF0; words[1] = 8'h0F;
        exp16 = 16'b1111000000001111;
        begin
            int idx = 0;
            int pos = 0;
            bit started = 1'b0;
            for (int cyc = 0; cyc < 40 && pos < 17; cyc++) begin
                if (idx < 2) begin
                    bus0.din = words[idx];
                    bus0.din_valid = 1'b1;
                end else begin
                    bus0.din_valid = 1'b0;
                end
                #1;
                if (bus0.din_valid && bus0.din_ready) idx++;
                step();
                if (ws0) started = 1'b1;
                if (started) begin
                    if (pos < 16) begin
                        check("t2_bit", dout0, exp16[15 - pos]);
                        check("t2_ws", ws0, (pos % 8 == 0));
                        check("t2_uf", uf0, 1'b0);
                    end else begin
                        check("t2_end_dout", dout0, IDLE);
                        check("t2_end_uf", uf0, 1'b1);
                    end
                    pos++;
                end
            end
            check("t2_len", pos, 17);
        end
        bus0.din_valid = 1'b0;
        clr_err = 1'b1; step(); clr_err = 1'b0;

        // en low for three cycles mid-word
        bus0.din = 8'hC6; bus0.din_valid = 1'b1;
        step();
        bus0.din_valid = 1'b0;
        pat = 8'hC6;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_bit", dout0, pat[7 - i]);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_frozen", dout0, pat[5]);
            check("t3_ws_off", ws0, 1'b0);
        end
        en = 1'b1;
        for (int i = 3; i < 8; i++) begin
            step();
            check("t3_resume", dout0, pat[7 - i]);
        end
        step();
        check("t3_uf", uf0, 1'b1);
        clr_err = 1'b1; step(); clr_err = 1'b0;

        // Reset at bit 4 with the hold register full
        bus0.din = 8'hA5; bus0.din_valid = 1'b1;
        step();
        bus0.din = 8'h3C;
        step();
        step();
        bus0.din_valid = 1'b0;
        step(); step(); step();
        pat = 8'hA5;
        check("t4_bit4", dout0, pat[3]);
        check("t4_hold_full", bus0.din_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t4_dout", dout0, IDLE);
        check("t4_ws", ws0, 1'b0);
        check("t4_ready", bus0.din_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_quiet_dout", dout0, IDLE);
            check("t4_quiet_ws", ws0, 1'b0);
        end

        // PRBS7 right after reset
        rst = 1'b1;
        step();
        rst = 1'b0; prbs_en = 1'b1;
        for (int i = 0; i < 254; i++) begin
            step();
            prbs_bits[i] = dout0;
            check("t5_ready", bus0.din_ready, 1'b0);
        end
        for (int i = 0; i < 8; i++) check("t5_head", prbs_bits[i], (i < 7));
        for (int i = 0; i < 127; i++) check("t5_period", prbs_bits[i + 127], prbs_bits[i]);
        begin
            int run = 0;
            int max_run = 0;
            for (int i = 0; i < 254; i++) begin
                run = prbs_bits[i] ? 0 : run + 1;
                if (run > max_run) max_run = run;
            end
            check("t5_zero_run_ok", (max_run < 7), 1'b1);
        end
        prbs_en = 1'b0;
        step();
        check("t5_exit_idle", dout0, IDLE);
        bus0.din = 8'h5A; bus0.din_valid = 1'b1;
        step();
        bus0.din_valid = 1'b0;
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_word_bit", dout0, pat[7 - i]);
        end
        step();

        // LSB-first instance, word 01
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus1.din = 8'h01; bus1.din_valid = 1'b1;
        step();
        bus1.din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t6_bit", dout1, (i == 0));
            check("t6_ws", ws1, (i == 0));
        end
        step();
        check("t6_idle", dout1, IDLE);
        check("t6_uf", uf1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
